// File: rtl/param_serial_conv_engine.sv
// param_serial_conv_engine
//   Single-PE 2-D convolution engine. One multiply-accumulate datapath is
//   time-multiplexed over every filter tap of every output position of an
//   IN_N x IN_N tile convolved with a K x K filter (valid region, ON = IN_N-K+1).
//   Operands and mode bits are snapshotted when a job starts.
// Ports
//   clk_in   : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : one-cycle job request, accepted only when idle
//   corr     : 0 = convolution (flipped filter), 1 = correlation
//   sat      : 0 = wrap to DW bits, 1 = saturate to 2^DW-1
//   in_flat  : input tile, element (r,c) at [(r*IN_N+c)*DW +: DW]
//   flt_flat : filter, element (u,v) at [(u*K+v)*DW +: DW]
//   out_flat : results, element (r,c) at [(r*ON+c)*DW +: DW]
//   busy     : high whenever not idle
//   done     : one-cycle pulse after the last output is written
module param_serial_conv_engine #(
  parameter int unsigned IN_N = 4,
  parameter int unsigned K    = 3,
  parameter int unsigned DW   = 8
) (
  input  logic                                    clk_in,
  input  logic                                    rst,
  input  logic                                    start,
  input  logic                                    corr,
  input  logic                                    sat,
  input  logic [IN_N*IN_N*DW-1:0]                 in_flat,
  input  logic [K*K*DW-1:0]                       flt_flat,
  output logic [(IN_N-K+1)*(IN_N-K+1)*DW-1:0]     out_flat,
  output logic                                    busy,
  output logic                                    done
);

  localparam int unsigned ON = IN_N - K + 1;
  localparam int unsigned AW = 2 * DW + $clog2(K * K);
  // Wide enough for every tap and output counter (all are < IN_N).
  localparam int unsigned CW = $clog2(IN_N + 1);

  typedef enum logic [1:0] {StIdle, StMac, StDone} state_e;

  state_e                     state_q, state_d;
  logic [CW-1:0]              u_q, u_d, v_q, v_d, r_q, r_d, c_q, c_d;
  logic [AW-1:0]              acc_q, acc_d;
  logic [IN_N*IN_N*DW-1:0]    in_q, in_d;
  logic [K*K*DW-1:0]          flt_q, flt_d;
  logic                       corr_q, corr_d, sat_q, sat_d;
  logic [ON*ON*DW-1:0]        out_q, out_d;

  // Datapath signals
  int unsigned                pix_idx, flt_idx, out_idx;
  logic [DW-1:0]              pix, coef, res;
  logic [AW-1:0]              prod, sum;
  logic                       first_tap, last_tap, last_out;

  always_comb begin
    first_tap = (u_q == '0) && (v_q == '0);
    last_tap  = (u_q == CW'(K - 1)) && (v_q == CW'(K - 1));
    last_out  = (r_q == CW'(ON - 1)) && (c_q == CW'(ON - 1));

    pix_idx = (int'(r_q) + int'(u_q)) * IN_N + int'(c_q) + int'(v_q);
    // Convolution walks the filter back to front; correlation walks it in order.
    if (corr_q) flt_idx = int'(u_q) * K + int'(v_q);
    else        flt_idx = (K - 1 - int'(u_q)) * K + (K - 1 - int'(v_q));
    out_idx = int'(r_q) * ON + int'(c_q);

    pix  = in_q[pix_idx*DW +: DW];
    coef = flt_q[flt_idx*DW +: DW];
    prod = {{(AW-DW){1'b0}}, pix} * {{(AW-DW){1'b0}}, coef};
    // Tap (0,0) loads rather than adds, so no clear cycle between outputs.
    sum  = (first_tap ? '0 : acc_q) + prod;

    if (sat_q && (|sum[AW-1:DW])) res = '1;
    else                          res = sum[DW-1:0];
  end

  always_comb begin
    state_d = state_q;
    u_d     = u_q;
    v_d     = v_q;
    r_d     = r_q;
    c_d     = c_q;
    acc_d   = acc_q;
    in_d    = in_q;
    flt_d   = flt_q;
    corr_d  = corr_q;
    sat_d   = sat_q;
    out_d   = out_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StMac;
          in_d    = in_flat;
          flt_d   = flt_flat;
          corr_d  = corr;
          sat_d   = sat;
          u_d     = '0;
          v_d     = '0;
          r_d     = '0;
          c_d     = '0;
        end
      end
      StMac: begin
        acc_d = sum;
        if (last_tap) begin
          out_d[out_idx*DW +: DW] = res;
          u_d = '0;
          v_d = '0;
          if (last_out) begin
            r_d     = '0;
            c_d     = '0;
            state_d = StDone;
          end else if (c_q == CW'(ON - 1)) begin
            c_d = '0;
            r_d = r_q + 1'b1;
          end else begin
            c_d = c_q + 1'b1;
          end
        end else if (v_q == CW'(K - 1)) begin
          v_d = '0;
          u_d = u_q + 1'b1;
        end else begin
          v_d = v_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q <= StIdle;
      u_q     <= '0;
      v_q     <= '0;
      r_q     <= '0;
      c_q     <= '0;
      acc_q   <= '0;
      in_q    <= '0;
      flt_q   <= '0;
      corr_q  <= 1'b0;
      sat_q   <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      u_q     <= u_d;
      v_q     <= v_d;
      r_q     <= r_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      in_q    <= in_d;
      flt_q   <= flt_d;
      corr_q  <= corr_d;
      sat_q   <= sat_d;
      out_q   <= out_d;
    end
  end

  assign out_flat = out_q;
  assign busy     = (state_q != StIdle);
  assign done     = (state_q == StDone);

endmodule
